// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/busy/done handshake and a multi-cycle
// shift-add multiplier producing a double-width product.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      request, sampled only while busy=0
//   op         operation code
//   a, b       operands, latched at the accepting edge
//   busy       multiplier in progress
//   done       one-cycle pulse, result and flags valid
//   result     result (low half of the product for MUL)
//   result_hi  high half of the product for MUL, 0 otherwise
//   flag_z     result == 0
//   flag_cy    carry / borrow / shift-out / MUL high half non-zero
//   flag_ov    signed overflow for add/sub-type ops
//   flag_p     even parity of result
//   flag_s     result MSB
module alu_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_cy,
  output logic             flag_ov,
  output logic             flag_p,
  output logic             flag_s
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpNot = 4'd0;
  localparam logic [3:0] OpXor = 4'd1;
  localparam logic [3:0] OpOr  = 4'd2;
  localparam logic [3:0] OpAnd = 4'd3;
  localparam logic [3:0] OpSub = 4'd4;
  localparam logic [3:0] OpAdd = 4'd5;
  localparam logic [3:0] OpRr  = 4'd6;
  localparam logic [3:0] OpRl  = 4'd7;
  localparam logic [3:0] OpDec = 4'd8;
  localparam logic [3:0] OpInc = 4'd9;
  localparam logic [3:0] OpAdc = 4'd10;
  localparam logic [3:0] OpSbb = 4'd11;
  localparam logic [3:0] OpMul = 4'd12;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     result_hi_q, result_hi_d;
  logic                 done_q, done_d;
  logic                 z_q, z_d, cy_q, cy_d, ov_q, ov_d, p_q, p_d, s_q, s_d;

  // Single-cycle datapath
  logic [WIDTH:0]       ext_a, ext_b, ext_one, ext_cin, wide;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_cy, alu_ov;

  // Multiplier step: conditionally add the multiplicand into the high half,
  // then shift the whole {carry, hi, lo} right by one.
  logic [WIDTH:0]       step_sum;
  logic [2*WIDTH-1:0]   prod_step;

  function automatic logic add_ov(input logic x, input logic y, input logic r);
    return (x == y) && (r != x);
  endfunction

  function automatic logic sub_ov(input logic x, input logic y, input logic r);
    return (x != y) && (r != x);
  endfunction

  assign ext_a   = {1'b0, a};
  assign ext_b   = {1'b0, b};
  assign ext_one = {{WIDTH{1'b0}}, 1'b1};
  assign ext_cin = {{WIDTH{1'b0}}, cy_q};

  always_comb begin
    wide    = '0;
    alu_res = a;
    alu_cy  = cy_q;  // logic and reserved ops keep the previous carry
    alu_ov  = 1'b0;
    unique case (op)
      OpNot: alu_res = ~a;
      OpXor: alu_res = a ^ b;
      OpOr:  alu_res = a | b;
      OpAnd: alu_res = a & b;
      OpSub: begin
        wide    = ext_a - ext_b;
        alu_res = wide[WIDTH-1:0];
        alu_cy  = wide[WIDTH];
        alu_ov  = sub_ov(a[WIDTH-1], b[WIDTH-1], wide[WIDTH-1]);
      end
      OpAdd: begin
        wide    = ext_a + ext_b;
        alu_res = wide[WIDTH-1:0];
        alu_cy  = wide[WIDTH];
        alu_ov  = add_ov(a[WIDTH-1], b[WIDTH-1], wide[WIDTH-1]);
      end
      OpRr: begin
        alu_res = {1'b0, a[WIDTH-1:1]};
        alu_cy  = a[0];
      end
      OpRl: begin
        alu_res = {a[WIDTH-2:0], 1'b0};
        alu_cy  = a[WIDTH-1];
      end
      OpDec: begin
        wide    = ext_a - ext_one;
        alu_res = wide[WIDTH-1:0];
        alu_cy  = wide[WIDTH];
        alu_ov  = sub_ov(a[WIDTH-1], 1'b0, wide[WIDTH-1]);
      end
      OpInc: begin
        wide    = ext_a + ext_one;
        alu_res = wide[WIDTH-1:0];
        alu_cy  = wide[WIDTH];
        alu_ov  = add_ov(a[WIDTH-1], 1'b0, wide[WIDTH-1]);
      end
      OpAdc: begin
        wide    = ext_a + ext_b + ext_cin;
        alu_res = wide[WIDTH-1:0];
        alu_cy  = wide[WIDTH];
        alu_ov  = add_ov(a[WIDTH-1], b[WIDTH-1], wide[WIDTH-1]);
      end
      OpSbb: begin
        // Bit WIDTH of the (WIDTH+1)-bit difference is set exactly when b+cy > a
        wide    = ext_a - ext_b - ext_cin;
        alu_res = wide[WIDTH-1:0];
        alu_cy  = wide[WIDTH];
        alu_ov  = sub_ov(a[WIDTH-1], b[WIDTH-1], wide[WIDTH-1]);
      end
      default: alu_res = a;
    endcase
  end

  assign step_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                     (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
  assign prod_step = {step_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    done_d      = 1'b0;
    cy_d        = cy_q;
    ov_d        = ov_q;
    z_d         = z_q;
    p_d         = p_q;
    s_d         = s_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op == OpMul) begin
            state_d = StMul;
            cnt_d   = CntW'(WIDTH);
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
          end else begin
            done_d      = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            cy_d        = alu_cy;
            ov_d        = alu_ov;
          end
        end
      end
      StMul: begin
        prod_d = prod_step;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          result_d    = prod_step[WIDTH-1:0];
          result_hi_d = prod_step[2*WIDTH-1:WIDTH];
          cy_d        = |prod_step[2*WIDTH-1:WIDTH];
          ov_d        = 1'b0;
        end
      end
    endcase
    // z/p/s follow the final (low-half) result whenever one is delivered
    if (done_d) begin
      z_d = (result_d == '0);
      p_d = ~^result_d;
      s_d = result_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      done_q      <= 1'b0;
      z_q         <= 1'b0;
      cy_q        <= 1'b0;
      ov_q        <= 1'b0;
      p_q         <= 1'b0;
      s_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      done_q      <= done_d;
      z_q         <= z_d;
      cy_q        <= cy_d;
      ov_q        <= ov_d;
      p_q         <= p_d;
      s_q         <= s_d;
    end
  end

  assign busy      = (state_q == StMul);
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag_z    = z_q;
  assign flag_cy   = cy_q;
  assign flag_ov   = ov_q;
  assign flag_p    = p_q;
  assign flag_s    = s_q;

endmodule
